// File: rtl/ip_rx_hdr_check.sv
// ip_rx_hdr_check: IPv4 receive header parser with checksum, version/length and destination checks
//
// Parameters
//   LOCAL_IP  : station IPv4 address compared against the destination field
//   CHECK_DST : 1 = destination must equal LOCAL_IP, 0 = accept any destination
// Ports
//   Clk, Reset_n        : rising-edge clock, synchronous active-low reset
//   in_data/in_valid    : header byte stream, network order; gaps allowed
//   in_sof              : marks byte 0 (ver/hdr_len), qualified by in_valid
//   hdr_done            : one-cycle pulse when a header has been evaluated
//   hdr_ok/err_code     : verdict and reasons {dst mismatch, bad ver/len, bad checksum}
//   ver ... dst_ip      : captured header fields
module ip_rx_hdr_check #(
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0002,
    parameter int          CHECK_DST = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        hdr_done,
    output logic        hdr_ok,
    output logic [2:0]  err_code,
    output logic [3:0]  ver,
    output logic [3:0]  hdr_len,
    output logic [7:0]  tos,
    output logic [15:0] total_len,
    output logic [15:0] id,
    output logic [15:0] offset,
    output logic [7:0]  ttl,
    output logic [7:0]  protocol,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip
);
    typedef enum logic [2:0] {IDLE, HDR, FOLD1, FOLD2, DONE} state_t;

    state_t      state, nxt;
    logic [5:0]  cnt;
    logic [7:0]  hi;
    logic [20:0] acc;
    logic [16:0] sum;
    logic        cks_ok;
    logic        bad;
    logic        sof;
    logic        bad0;
    logic        last;
    logic [5:0]  last_idx;
    logic [2:0]  verdict;

    always_comb begin
        sof      = in_valid && in_sof;
        bad0     = (in_data[7:4] != 4'd4) || (in_data[3:0] < 4'd5);
        last_idx = {hdr_len, 2'b00} - 6'd1;
        last     = in_valid && (cnt == last_idx);
        // a malformed byte 0 means no checksum or destination was ever seen
        verdict  = bad ? 3'b010 : {(CHECK_DST != 0) && (dst_ip != LOCAL_IP), 1'b0, ~cks_ok};
        nxt      = state;
        case (state)
            IDLE:    nxt = IDLE;
            HDR:     nxt = last ? FOLD1 : HDR;
            FOLD1:   nxt = FOLD2;
            FOLD2:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // a start-of-frame always restarts capture from that byte
        if (sof) nxt = bad0 ? DONE : HDR;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cnt       <= 6'd0;
            hi        <= 8'd0;
            acc       <= 21'd0;
            sum       <= 17'd0;
            cks_ok    <= 1'b0;
            bad       <= 1'b0;
            hdr_done  <= 1'b0;
            hdr_ok    <= 1'b0;
            err_code  <= 3'd0;
            ver       <= 4'd0;
            hdr_len   <= 4'd0;
            tos       <= 8'd0;
            total_len <= 16'd0;
            id        <= 16'd0;
            offset    <= 16'd0;
            ttl       <= 8'd0;
            protocol  <= 8'd0;
            src_ip    <= 32'd0;
            dst_ip    <= 32'd0;
        end else begin
            state    <= nxt;
            hdr_done <= state == DONE;
            if (state == DONE) begin
                hdr_ok   <= verdict == 3'b000;
                err_code <= verdict;
            end
            if (state == FOLD1) sum <= {1'b0, acc[15:0]} + {12'd0, acc[20:16]};
            // second fold cannot carry: a carry out of FOLD1 leaves sum[15:0] tiny
            if (state == FOLD2) cks_ok <= (sum[15:0] + {15'd0, sum[16]}) == 16'hFFFF;
            if (sof) begin
                ver     <= in_data[7:4];
                hdr_len <= in_data[3:0];
                bad     <= bad0;
                cnt     <= 6'd1;
                hi      <= in_data;
                acc     <= 21'd0;
            end else if (in_valid && state == HDR) begin
                cnt <= cnt + 6'd1;
                if (cnt[0]) acc <= acc + {5'd0, hi, in_data};
                else        hi  <= in_data;
                case (cnt)
                    6'd1:                      tos       <= in_data;
                    6'd2, 6'd3:                total_len <= {total_len[7:0], in_data};
                    6'd4, 6'd5:                id        <= {id[7:0], in_data};
                    6'd6, 6'd7:                offset    <= {offset[7:0], in_data};
                    6'd8:                      ttl       <= in_data;
                    6'd9:                      protocol  <= in_data;
                    6'd12, 6'd13, 6'd14, 6'd15: src_ip   <= {src_ip[23:0], in_data};
                    6'd16, 6'd17, 6'd18, 6'd19: dst_ip   <= {dst_ip[23:0], in_data};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/ip_rx_hdr_check.md
IP_RX_HDR_CHECK -- requirements
Module: ip_rx_hdr_check

Interface
REQ-001 The block SHALL have parameter LOCAL_IP, default 32'hC0A8_0002, the station IPv4 address compared against the destination address.
REQ-002 The block SHALL have parameter CHECK_DST, default 1, where 1 enables the destination-address match and 0 accepts any destination.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port Reset_n, input, 1 bit, the synchronous active-low reset.
REQ-005 The block SHALL have port in_data, input, 8 bits, the IP header byte stream, MSB-first, network order.
REQ-006 The block SHALL have port in_valid, input, 1 bit, which qualifies in_data; gaps between bytes are allowed.
REQ-007 The block SHALL have port in_sof, input, 1 bit, which marks the first byte (ver/hdr_len) and is meaningful only with in_valid.
REQ-008 The block SHALL have port hdr_done, output, 1 bit, a one-cycle pulse indicating that the header has been evaluated.
REQ-009 The block SHALL have port hdr_ok, output, 1 bit, the verdict, valid while hdr_done=1 and held until the next hdr_done.
REQ-010 The block SHALL have outputs ver[3:0], hdr_len[3:0], tos[7:0], total_len[15:0], id[15:0], offset[15:0], ttl[7:0], protocol[7:0], src_ip[31:0] and dst_ip[31:0], which are the captured fields, stable from hdr_done until the next in_sof.
REQ-011 The block SHALL have port err_code, output, 3 bits, where bit0 = checksum bad, bit1 = ver!=4 or hdr_len<5, and bit2 = destination mismatch.

Function
REQ-012 The block SHALL implement states IDLE, HDR, FOLD1, FOLD2 and DONE.
REQ-013 In IDLE, in_valid&in_sof SHALL capture byte 0, set byte count to 1, load the accumulator with {in_data,8'h00} held pending, and transition to HDR; bytes received without in_sof SHALL be ignored.
REQ-014 In HDR, each in_valid byte at index k SHALL increment the count; an even k SHALL be latched as the high byte, and an odd k SHALL add {high,in_data} to a 21-bit accumulator.
REQ-015 Field capture SHALL be by byte index: 0 ver/hdr_len, 1 tos, 2-3 total_len, 4-5 id, 6-7 offset, 8 ttl, 9 protocol, 10-11 checksum (which is summed and not stored separately), 12-15 src_ip, 16-19 dst_ip, and 20 and above options (summed, not stored).
REQ-016 If hdr_len<5 or ver!=4 is seen at byte 0, the block SHALL set err_code[1] and go directly to DONE on the next cycle.
REQ-017 When byte index hdr_len*4-1 is accepted, the block SHALL transition to FOLD1.
REQ-018 FOLD1 SHALL compute sum = acc[15:0] + acc[20:16] into a 17-bit value.
REQ-019 FOLD2 SHALL compute sum = sum[15:0] + sum[16], and check that the result equals 16'hFFFF.
REQ-020 hdr_done SHALL assert exactly 3 cycles after the clock edge that accepts the last header byte (FOLD1, FOLD2, DONE), and SHALL be high for 1 cycle.
REQ-021 In DONE, hdr_ok SHALL be 1 if and only if err_code==0, where err_code[2] is set when CHECK_DST=1 and dst_ip!=LOCAL_IP; the block SHALL return to IDLE next.
REQ-022 in_valid&in_sof while in HDR, FOLD1 or FOLD2 SHALL abort the current header with no hdr_done and restart capture from that byte as byte 0.
REQ-023 in_valid&in_sof during DONE SHALL be accepted as byte 0 of the next header, with the DONE pulse still issued.
REQ-024 In FOLD1 and FOLD2, bytes received with in_valid=1 and in_sof=0 SHALL be ignored.
REQ-025 The accumulator SHALL NOT overflow; the maximum of 30 halfwords × 16'hFFFF is less than 2^21.

Reset
REQ-026 While Reset_n=0 at a clock edge, the state SHALL go to IDLE and the accumulator and count SHALL be cleared.
REQ-027 While Reset_n=0 at a clock edge, hdr_done, hdr_ok, err_code and all field outputs SHALL be set to 0.
REQ-028 A reset asserted mid-header SHALL discard that header with no hdr_done.
REQ-029 The first in_sof after Reset_n returns high SHALL be accepted normally.

Verification
REQ-030 The bench SHALL drive valid header bytes 45 00 00 73 00 00 40 00 40 11 B8 61 C0 A8 00 01 C0 A8 00 C7 with LOCAL_IP=C0A800C7, and SHALL check that hdr_done occurs 3 cycles after the last byte with hdr_ok=1, err_code=0, total_len=0073, protocol=11, src_ip=C0A80001 and ttl=40.
REQ-031 The bench SHALL drive the same header with the checksum bytes changed to B8 62, and SHALL check hdr_ok=0 and err_code=3'b001.
REQ-032 The bench SHALL drive the same header with CHECK_DST=1 and LOCAL_IP=C0A80002, and SHALL check err_code=3'b100 and hdr_ok=0; with CHECK_DST=0 it SHALL check hdr_ok=1.
REQ-033 The bench SHALL drive a first byte of 0x44 with in_sof, and SHALL check hdr_done 1 cycle later with err_code=3'b010 and no further bytes consumed.
REQ-034 The bench SHALL drive a 24-byte header (0x46, options 01 01 01 00, checksum recomputed) with random in_valid gaps, and SHALL check hdr_ok=1 and hdr_done exactly 3 cycles after byte 23.
REQ-035 The bench SHALL issue in_sof at byte 7 of a header followed by a full valid header, and SHALL check that exactly one hdr_done occurs with hdr_ok=1; it SHALL also pulse Reset_n low at byte 10 and check that no hdr_done occurs and that all outputs are 0.
